nand_share_arbiter: RTL and testbench

Round-robin arbiter that shares a single registered NAND evaluation unit among N_REQ requesters. Each requester presents a req plus 1-bit operands. The block grants one requester at a time, captures its operands, evaluates res = ~(a & b), and returns the result tagged with the requester id. It uses a valid/ready output handshake with full backpressure. It sits between the gate-level component library and any multi-client logic needing a shared gate resource.

---
 rtl/nand_arb_pkg.sv | 13 +
 rtl/nand_share_arbiter_rr_pick.sv | 27 ++
 rtl/nand_share_arbiter.sv | 90 +++++++++
 tb/tb_nand_share_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/nand_arb_pkg.sv
// nand_arb_pkg: shared sizing, reset values and helpers for the NAND-sharing arbiter
package nand_arb_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int ID_W_DEF  = $clog2(N_REQ_DEF);
    localparam logic RST_RES   = 1'b0;
    localparam logic RST_VALID = 1'b0;
    localparam logic RST_S1_V  = 1'b0;
    localparam logic RST_OP    = 1'b0;

    function automatic logic [15:0] onehot(input logic [3:0] id);
        return 16'(1) << id;
    endfunction
endpackage

// File: rtl/nand_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr and wrapping
module rr_pick
    import nand_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   eff_req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] w,
    output logic [N-1:0]   oh
);
    logic [15:0] w_oh16;

    // Scan farthest-first so the nearest requester after ptr overwrites the rest
    always_comb begin
        w = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (eff_req[(int'(ptr) + k) % N]) w = IDW'((int'(ptr) + k) % N);
        end
    end

    assign any    = |eff_req;
    assign w_oh16 = onehot(4'(w));
    assign oh     = any ? w_oh16[N-1:0] : '0;
endmodule

// File: rtl/nand_share_arbiter.sv
// nand_share_arbiter: round-robin sharing of one registered NAND unit with valid/ready output
module nand_share_arbiter
    import nand_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] a_in,
    input  logic [N_REQ-1:0] b_in,
    output logic [N_REQ-1:0] gnt,
    output logic             res,
    output logic             res_valid,
    output logic [ID_W-1:0]  res_id,
    input  logic             res_ready,
    output logic             busy
);
    logic [N_REQ-1:0] r_gnt;
    logic             r_res;
    logic             r_res_valid;
    logic [ID_W-1:0]  r_res_id;
    logic             r_s1_v;
    logic             r_op_a;
    logic             r_op_b;
    logic [ID_W-1:0]  r_op_id;
    logic [ID_W-1:0]  r_ptr;

    logic             w_out_adv;
    logic             w_s1_adv;
    logic             w_issue;
    logic             w_any;
    logic [ID_W-1:0]  w_w;
    logic [N_REQ-1:0] w_oh;
    logic [N_REQ-1:0] w_eff_req;

    // The requester seeing gnt this cycle is masked so a held req is not double-served
    assign w_eff_req = req & ~r_gnt;
    assign w_out_adv = !r_res_valid | res_ready;
    assign w_s1_adv  = r_s1_v & w_out_adv;
    assign w_issue   = w_any & (!r_s1_v | w_s1_adv);

    rr_pick #(.N(N_REQ), .IDW(ID_W)) u_pick (
        .eff_req (w_eff_req),
        .ptr     (r_ptr),
        .any     (w_any),
        .w       (w_w),
        .oh      (w_oh)
    );

    // Two-stage pipeline: grant/operand capture, then NAND evaluation into the output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt       <= '0;
            r_res       <= RST_RES;
            r_res_valid <= RST_VALID;
            r_res_id    <= '0;
            r_s1_v      <= RST_S1_V;
            r_op_a      <= RST_OP;
            r_op_b      <= RST_OP;
            r_op_id     <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_s1_adv) begin
                r_res       <= ~(r_op_a & r_op_b);
                r_res_id    <= r_op_id;
                r_res_valid <= 1'b1;
            end else if (w_out_adv) begin
                r_res_valid <= 1'b0;
            end
            r_gnt <= w_issue ? w_oh : '0;
            if (w_issue) begin
                r_op_a  <= a_in[w_w];
                r_op_b  <= b_in[w_w];
                r_op_id <= w_w;
                r_s1_v  <= 1'b1;
                r_ptr   <= (w_w == ID_W'(N_REQ - 1)) ? '0 : w_w + 1'b1;
            end else if (w_s1_adv) begin
                r_s1_v <= 1'b0;
            end
        end
    end

    assign gnt       = r_gnt;
    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign busy      = r_s1_v | r_res_valid;
endmodule

// File: tb/tb_nand_share_arbiter.sv
// tb_nand_share_arbiter: directed checks of grant order, latency, backpressure and reset
module tb_nand_share_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, a_in, b_in, gnt;
    logic       res, res_valid, res_ready, busy;
    logic [1:0] res_id;
    int         checks = 0;
    int         errors = 0;

    nand_share_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .res       (res),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b1111; a_in = 4'b0000; b_in = 4'b0000; res_ready = 1'b1;
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(res_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        chk("first_res", 32'(res), 32'h1);
        chk("first_valid", 32'(res_valid), 32'h1);
        chk("first_id", 32'(res_id), 32'h0);
        tick();
        chk("first_clear", 32'(res_valid), 32'h0);

        req = 4'b0100; a_in = 4'b0100; b_in = 4'b0100;
        tick();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_novalid", 32'(res_valid), 32'h0);
        req = 4'b0000;
        tick();
        chk("single_gnt_off", 32'(gnt), 32'h0);
        chk("single_res", 32'(res), 32'h0);
        chk("single_id", 32'(res_id), 32'h2);
        chk("single_valid", 32'(res_valid), 32'h1);
        tick();
        chk("single_1cyc", 32'(res_valid), 32'h0);

        req = 4'b1001; a_in = 4'b1001; b_in = 4'b1001;
        tick();
        chk("wrap_gnt3", 32'(gnt), 32'h8);
        req = 4'b0001;
        tick();
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        chk("wrap_id3", 32'(res_id), 32'h3);
        chk("wrap_res3", 32'(res), 32'h0);
        req = 4'b0000;
        tick();
        chk("wrap_id0", 32'(res_id), 32'h0);
        chk("wrap_gnt_off", 32'(gnt), 32'h0);
        tick();
        chk("wrap_idle", 32'(busy), 32'h0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req = 4'b1111; a_in = 4'b0000; b_in = 4'b1111;
        tick();
        chk("fair_g0", 32'(gnt), 32'h1);
        tick();
        chk("fair_g1", 32'(gnt), 32'h2);
        chk("fair_r0", 32'({res_valid, res, res_id}), 32'hC);
        tick();
        chk("fair_g2", 32'(gnt), 32'h4);
        chk("fair_r1", 32'({res_valid, res, res_id}), 32'hD);
        tick();
        chk("fair_g3", 32'(gnt), 32'h8);
        chk("fair_r2", 32'({res_valid, res, res_id}), 32'hE);
        tick();
        chk("fair_g0b", 32'(gnt), 32'h1);
        chk("fair_r3", 32'({res_valid, res, res_id}), 32'hF);
        tick();
        chk("fair_g1b", 32'(gnt), 32'h2);
        chk("fair_r0b", 32'({res_valid, res, res_id}), 32'hC);
        req = 4'b0000;
        tick();
        chk("fair_r1b", 32'({res_valid, res, res_id}), 32'hD);
        tick();
        chk("fair_drain", 32'(busy), 32'h0);

        res_ready = 1'b0; req = 4'b0011; a_in = 4'b0011; b_in = 4'b0011;
        tick();
        chk("bp_g0", 32'(gnt), 32'h1);
        req = 4'b0010;
        tick();
        chk("bp_g1", 32'(gnt), 32'h2);
        chk("bp_v0", 32'({res_valid, res, res_id}), 32'h8);
        req = 4'b0100;
        tick();
        chk("bp_stall_gnt", 32'(gnt), 32'h0);
        chk("bp_stall_busy", 32'(busy), 32'h1);
        tick();
        chk("bp_stall_gnt2", 32'(gnt), 32'h0);
        chk("bp_hold", 32'({res_valid, res, res_id}), 32'h8);
        req = 4'b0000; res_ready = 1'b1;
        tick();
        chk("bp_drain1", 32'({res_valid, res, res_id}), 32'h9);
        tick();
        chk("bp_done_valid", 32'(res_valid), 32'h0);
        chk("bp_done_busy", 32'(busy), 32'h0);

        res_ready = 1'b0; req = 4'b0001; a_in = 4'b0000; b_in = 4'b0000;
        tick();
        chk("mr_g0", 32'(gnt), 32'h1);
        req = 4'b0010;
        tick();
        chk("mr_full", 32'({busy, res_valid}), 32'h3);
        req = 4'b0000; rst_n = 1'b0;
        tick();
        chk("mr_valid", 32'(res_valid), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_gnt", 32'(gnt), 32'h0);
        rst_n = 1'b1; res_ready = 1'b1;
        tick();
        chk("mr_no_ghost", 32'({busy, res_valid}), 32'h0);
        req = 4'b1111;
        tick();
        chk("mr_ptr0", 32'(gnt), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
